// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the shared FP add/sub arbiter.
// State encoding includes EXEC2, used only with FPU_ARB_OUT_REG_EN.
package fpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        EXEC2 = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
    } fp_op_t;

    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO   = 32'h4000_0000;
    localparam logic [31:0] FP_THREE = 32'h4040_0000;
    localparam logic [31:0] FP_INF   = 32'h7F80_0000;

endpackage

// File: rtl/fpu_addsub_arbiter_addsub.sv
// Single-precision add/sub datapath: align, add or subtract, normalise,
// truncate. Any operand with exponent 255 raises exception_o, result 0.
module Addition_Subtraction (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] result_o,
    output logic        exception_o
);

    logic        sb, swap, s_big, s_sml;
    logic [7:0]  e_big, e_sml, ediff, e_out;
    logic [22:0] f_big, f_sml;
    logic [23:0] m_big, m_sml, m_al, dif, m_norm;
    logic [24:0] sum;
    logic [4:0]  lead, shift;

    always_comb begin
        exception_o = (&a_i[30:23]) | (&b_i[30:23]);
        sb   = b_i[31] ^ sub_i;
        swap = b_i[30:0] > a_i[30:0];
        if (swap) begin
            {s_big, e_big, f_big} = {sb, b_i[30:0]};
            {s_sml, e_sml, f_sml} = {a_i[31], a_i[30:0]};
        end else begin
            {s_big, e_big, f_big} = {a_i[31], a_i[30:0]};
            {s_sml, e_sml, f_sml} = {sb, b_i[30:0]};
        end
        m_big = {|e_big, f_big};
        m_sml = {|e_sml, f_sml};
        ediff = e_big - e_sml;
        m_al  = (ediff > 8'd24) ? 24'd0 : (m_sml >> ediff);
        sum   = {1'b0, m_big} + {1'b0, m_al};
        dif   = m_big - m_al;
        lead  = '0;
        for (int i = 0; i < 24; i++) begin
            if (dif[i]) lead = 5'(i);
        end
        shift  = 5'd23 - lead;
        m_norm = dif << shift;
        e_out  = e_big - {3'b0, shift};
        result_o = '0;
        if (exception_o) begin
            result_o = '0;
        end else if (s_big == s_sml) begin
            if (sum[24]) begin
                // Carry out bumps the exponent; 254 -> 255 saturates to inf.
                if (e_big == 8'd254) begin
                    result_o = {s_big, 8'hFF, 23'd0};
                end else begin
                    result_o = {s_big, e_big + 8'd1, sum[23:1]};
                end
            end else if (e_big == 8'd0 && sum[23]) begin
                result_o = {s_big, 8'd1, sum[22:0]};
            end else begin
                result_o = {s_big, e_big, sum[22:0]};
            end
        end else if (dif == 24'd0 || e_big <= {3'b0, shift}) begin
            result_o = '0;
        end else begin
            result_o = {s_big, e_out, m_norm[22:0]};
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upward,
// wrapping modulo N_REQ, and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [ID_W:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) begin
                pos = pos - (ID_W+1)'(N_REQ);
            end
            if (!any_o && req_i[pos[ID_W-1:0]]) begin
                any_o                 = 1'b1;
                gnt_o[pos[ID_W-1:0]] = 1'b1;
                idx_o                 = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin shared FP add/sub unit, one op in flight. Define
// FPU_ARB_OUT_REG_EN to register the datapath output (adds EXEC2).
module fpu_addsub_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]    req_sub,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_result,
    output logic                rsp_exception,
    output logic                busy
);

    arb_state_e       state_q;
    logic [ID_W-1:0]  ptr_q, id_q, rsp_id_q;
    fp_op_t           op_q, sel;
    logic             rsp_valid_q, rsp_exc_q;
    logic [31:0]      rsp_res_q;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [31:0]      dp_res;
    logic             dp_exc;
`ifdef FPU_ARB_OUT_REG_EN
    logic [31:0]      pipe_res_q;
    logic             pipe_exc_q;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel.a   = req_a[32*i +: 32];
                sel.b   = req_b[32*i +: 32];
                sel.sub = req_sub[i];
            end
        end
    end

    Addition_Subtraction u_dp (
        .a_i         (op_q.a),
        .b_i         (op_q.b),
        .sub_i       (op_q.sub),
        .result_o    (dp_res),
        .exception_o (dp_exc)
    );

    assign req_ready     = (state_q == IDLE) ? gnt : '0;
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_res_q;
    assign rsp_exception = rsp_exc_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(N_REQ-1);
            id_q        <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_exc_q   <= 1'b0;
`ifdef FPU_ARB_OUT_REG_EN
            pipe_res_q  <= '0;
            pipe_exc_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        op_q    <= sel;
                        id_q    <= gnt_idx;
                        ptr_q   <= gnt_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
`ifdef FPU_ARB_OUT_REG_EN
                    pipe_res_q <= dp_res;
                    pipe_exc_q <= dp_exc;
                    state_q    <= EXEC2;
`else
                    rsp_res_q   <= dp_res;
                    rsp_exc_q   <= dp_exc;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`endif
                end
                EXEC2: begin
`ifdef FPU_ARB_OUT_REG_EN
                    rsp_res_q   <= pipe_res_q;
                    rsp_exc_q   <= pipe_exc_q;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
`else
                    state_q <= IDLE;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter: single ops, exception,
// backpressure, reset mid-op and round-robin fairness.
module tb_fpu_addsub_arbiter;
    import fpu_arb_pkg::*;

    localparam int N = 4;
`ifdef FPU_ARB_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]   req_sub = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_result;
    logic           rsp_exception;
    logic           busy;

    int n_chk = 0;
    int n_fail = 0;

    fpu_addsub_arbiter #(.N_REQ(N)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sub       (req_sub),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    task automatic do_op(input string tag, input int i,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] er,
                         input logic ee);
        bit ok;
        int n;
        set_op(i, a, b, s);
        req_valid[i] = 1'b1;
        #1;
        wait_ready(i, ok);
        check({tag, "_grant"}, 32'(ok), 32'd1);
        tick();
        req_valid[i] = 1'b0;
        wait_rsp(n);
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_id"}, 32'(rsp_id), 32'(i));
        check({tag, "_res"}, rsp_result, er);
        check({tag, "_exc"}, 32'(rsp_exception), 32'(ee));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        bit ok;
        int n;
        int e;
        tick();
        tick();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RESET = 1'b0;
        tick();
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_res", rsp_result, 32'd0);
        check("rst_exc", 32'(rsp_exception), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        do_op("add", 0, FP_ONE, FP_TWO, 1'b0, FP_THREE, 1'b0);
        do_op("sub", 2, FP_THREE, FP_ONE, 1'b1, FP_TWO, 1'b0);
        do_op("exc", 1, FP_INF, FP_ONE, 1'b0, 32'd0, 1'b1);

        // Backpressure with a second requester waiting.
        set_op(3, FP_ONE, FP_ONE, 1'b0);
        req_valid[3] = 1'b1;
        #1;
        wait_ready(3, ok);
        check("bp_grant", 32'(ok), 32'd1);
        tick();
        req_valid[3] = 1'b0;
        set_op(0, FP_TWO, FP_ONE, 1'b0);
        req_valid[0] = 1'b1;
        wait_rsp(n);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_res", rsp_result, FP_TWO);
            check("bp_id", 32'(rsp_id), 32'd3);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_vld_clr", 32'(rsp_valid), 32'd0);
        check("bp_next_gnt", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(n);
        check("bp2_id", 32'(rsp_id), 32'd0);
        check("bp2_res", rsp_result, FP_THREE);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while the op is in EXEC.
        set_op(1, FP_ONE, FP_ONE, 1'b0);
        req_valid[1] = 1'b1;
        #1;
        wait_ready(1, ok);
        check("mr_grant", 32'(ok), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        check("mr_busy_pre", 32'(busy), 32'd1);
        RESET = 1'b1;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("mr_valid2", 32'(rsp_valid), 32'd0);
        RESET = 1'b0;
        tick();
        tick();
        check("mr_valid3", 32'(rsp_valid), 32'd0);
        check("mr_busy3", 32'(busy), 32'd0);
        do_op("after_rst", 3, FP_THREE, FP_ONE, 1'b1, FP_TWO, 1'b0);

        // Round-robin with every requester active.
        for (int i = 0; i < N; i++) begin
            set_op(i, FP_ONE, FP_ONE, 1'(i % 2));
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            e = k % 4;
            for (int c = 0; c < 20; c++) begin
                if (req_ready != '0) break;
                tick();
            end
            check("rr_gnt", 32'(req_ready), 32'(1 << e));
            tick();
            wait_rsp(n);
            check("rr_id", 32'(rsp_id), 32'(e));
            check("rr_res", rsp_result, (e % 2 == 1) ? 32'd0 : FP_TWO);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
